double_tap_buffer: RTL

//  Sample-history ring buffer for the echo-cancellation datapath. Sits directly downstream of
//  sig16b_to_double: captures each converted 64-bit double on the converter's ready edge and keeps
//  the newest TAPS samples. On request it streams the history, newest first, to the adaptive-filter
//  MAC over a valid/ready handshake. Writes arriving mid-stream are deferred so each burst is a

---
 rtl/dtb_pkg.sv | 11 +
 rtl/double_tap_buffer_if.sv | 29 ++
 rtl/double_ring_store.sv | 34 +++
 rtl/double_tap_buffer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dtb_pkg.sv
// Shared defaults and FSM encoding for the double-precision tap history buffer.
package dtb_pkg;

  localparam int unsigned TAPS_DEFAULT = 16;
  localparam int unsigned DW_DEFAULT   = 64;

  // Burst controller states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/double_tap_buffer_if.sv
// Tap stream from the history buffer to the adaptive-filter MAC (valid/ready).
interface double_tap_buffer_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 4
);

  logic [DW-1:0] tap_out;
  logic          tap_valid;
  logic          tap_ready;
  logic [AW-1:0] tap_index;
  logic          tap_last;

  modport master (
    output tap_out,
    output tap_valid,
    output tap_index,
    output tap_last,
    input  tap_ready
  );

  modport slave (
    input  tap_out,
    input  tap_valid,
    input  tap_index,
    input  tap_last,
    output tap_ready
  );

endinterface

// File: rtl/double_ring_store.sv
// TAPS x DW register array: one write port, one registered read port with write-first forwarding.
module double_ring_store #(
  parameter int unsigned TAPS = 16,
  parameter int unsigned DW   = 64,
  parameter int unsigned AW   = $clog2(TAPS)
) (
  input  logic          clk_operation,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [TAPS];

  // Storage write and registered read; a same-cycle write to the read slot is forwarded so a
  // burst snapshot taken alongside a write sees the new sample.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        mem_q[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      rdata <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

endmodule

// File: rtl/double_tap_buffer.sv
// Sample-history ring buffer: captures converter samples on ready edges and streams the newest
// TAPS samples, newest first, as a consistent snapshot per burst.
module double_tap_buffer
  import dtb_pkg::*;
#(
  parameter int unsigned TAPS = TAPS_DEFAULT,
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned AW   = $clog2(TAPS)
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic                enable,
  input  logic [DW-1:0]       double_in,
  input  logic                ready_in,
  input  logic                start_burst,
  double_tap_buffer_if.master tap,
  output logic                busy,
  output logic                filled,
  output logic                overrun
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST_INDEX = AW'(TAPS - 1);

  logic [0:0]    state_q, state_d;
  logic          ready_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] index_q, index_d;
  logic [AW:0]   count_q, count_d;
  logic          pend_valid_q, pend_valid_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic          overrun_q, overrun_d;

  logic          write_event;
  logic          handshake;
  logic          is_last;
  logic          we;
  logic [DW-1:0] wdata;

  assign write_event = enable & ready_in & ~ready_q;
  assign handshake   = (state_q == ST_BURST) & tap.tap_ready;
  assign is_last     = (index_q == LAST_INDEX);

  // Next-state: direct/pending writes, snapshot pointer, burst sequencing
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    index_d      = index_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    overrun_d    = overrun_q;
    we           = 1'b0;
    wdata        = double_in;

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          // Commit cycle: the deferred sample goes first, a fresh event waits one more cycle
          we           = 1'b1;
          wdata        = pend_data_q;
          pend_valid_d = 1'b0;
          if (write_event) begin
            pend_valid_d = 1'b1;
            pend_data_d  = double_in;
          end
        end else if (write_event) begin
          we = 1'b1;
        end
        if (we) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (count_q != FULL_COUNT) begin
            count_d = count_q + (AW+1)'(1);
          end
        end
        if (start_burst && enable) begin
          state_d = ST_BURST;
          index_d = '0;
        end
        // Tracks the newest slot, including a write landing this cycle
        rd_ptr_d = wr_ptr_d - AW'(1);
      end
      ST_BURST: begin
        if (write_event) begin
          if (pend_valid_q) begin
            overrun_d = 1'b1;
          end
          pend_valid_d = 1'b1;
          pend_data_d  = double_in;
        end
        if (handshake) begin
          if (is_last) begin
            state_d  = ST_IDLE;
            index_d  = '0;
            rd_ptr_d = wr_ptr_q - AW'(1);
          end else begin
            index_d  = index_q + AW'(1);
            rd_ptr_d = rd_ptr_q - AW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      index_q      <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_in;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      index_q      <= index_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      overrun_q    <= overrun_d;
    end
  end

  // Read address is the next-cycle pointer so tap_out lines up with index_q
  double_ring_store #(
    .TAPS (TAPS),
    .DW   (DW),
    .AW   (AW)
  ) u_store (
    .clk_operation (clk_operation),
    .rst           (rst),
    .we            (we),
    .waddr         (wr_ptr_q),
    .wdata         (wdata),
    .raddr         (rd_ptr_d),
    .rdata         (tap.tap_out)
  );

  // Handshake and status outputs, all derived from registers
  always_comb begin
    busy          = (state_q == ST_BURST);
    tap.tap_valid = busy;
    tap.tap_index = index_q;
    tap.tap_last  = busy & is_last;
    filled        = (count_q == FULL_COUNT);
    overrun       = overrun_q;
  end

endmodule
